// File: rtl/hbwif_aligner_pkg.sv
// Shared types and constants for the HBWIF RX word aligner.
package hbwif_aligner_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int RELOCK_CNT_W = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hbwif_pattern_matcher.sv
// Compares every WIDTH-bit window of the concatenated word pair against the sync pattern.
module hbwif_pattern_matcher
    import hbwif_aligner_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic [2*WIDTH-2:0]         cat,
    input  logic [WIDTH-1:0]           pattern,
    output logic [WIDTH-1:0]           match,
    output logic [$clog2(WIDTH)-1:0]   kmin,
    output logic                       any_hit
);
    localparam int OW = $clog2(WIDTH);

    for (genvar k = 0; k < WIDTH; k++) begin : g_win
        assign match[k] = (cat[k +: WIDTH] == pattern);
    end

    assign any_hit = |match;

    // Walk downward so the lowest matching offset wins.
    always_comb begin
        kmin = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (match[k]) kmin = OW'(k);
        end
    end

endmodule

// File: rtl/hbwif_word_aligner.sv
// RX word aligner: finds the sync-pattern bit offset, locks after repeated agreement,
// and emits aligned words while locked.
module hbwif_word_aligner
    import hbwif_aligner_pkg::*;
#(
    parameter int               WIDTH        = 10,
    parameter logic [WIDTH-1:0] PATTERN      = 10'b0101111100,
    parameter int               LOCK_COUNT   = 4,
    parameter int               UNLOCK_COUNT = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           io_rx_in,
    input  logic                       io_rx_in_valid,
    input  logic                       io_bit_reverse,
    input  logic                       io_realign,
    output logic [WIDTH-1:0]           io_rx_out,
    output logic                       io_rx_out_valid,
    output logic                       io_locked,
    output logic [$clog2(WIDTH)-1:0]   io_offset,
    output logic [7:0]                 io_relock_count
);
    localparam int OW = $clog2(WIDTH);
    localparam int CW = $clog2(max2(LOCK_COUNT, UNLOCK_COUNT) + 1);
    localparam logic [CW-1:0] LOCK_C   = CW'(LOCK_COUNT);
    localparam logic [CW-1:0] UNLOCK_C = CW'(UNLOCK_COUNT);

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        prev_q, prev_d;
    logic [OW-1:0]           offset_q, offset_d;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
    logic [RELOCK_CNT_W-1:0] relock_q, relock_d;
    logic [WIDTH-1:0]        rx_out_q, rx_out_d;
    logic                    rx_out_valid_q, rx_out_valid_d;

    logic [WIDTH-1:0]        d_rev, d;
    logic [2*WIDTH-2:0]      cat;
    logic [WIDTH-1:0]        match;
    logic [OW-1:0]           kmin;
    logic                    any_hit, hit_same, hit_other;

    always_comb begin
        d_rev = '0;
        for (int i = 0; i < WIDTH; i++) d_rev[i] = io_rx_in[WIDTH-1-i];
    end

    assign d = io_bit_reverse ? d_rev : io_rx_in;
    // The top bit of {d, prev} never lands in any window, so it is dropped.
    assign cat = {d[WIDTH-2:0], prev_q};

    hbwif_pattern_matcher #(.WIDTH(WIDTH)) u_match (
        .cat     (cat),
        .pattern (PATTERN),
        .match   (match),
        .kmin    (kmin),
        .any_hit (any_hit)
    );

    assign hit_same  = match[offset_q];
    assign hit_other = any_hit & ~hit_same;
    assign cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        prev_d         = prev_q;
        offset_d       = offset_q;
        cnt_d          = cnt_q;
        relock_d       = relock_q;
        rx_out_d       = rx_out_q;
        rx_out_valid_d = 1'b0;
        if (io_rx_in_valid) begin
            prev_d         = d;
            rx_out_d       = cat[offset_q +: WIDTH];
            rx_out_valid_d = (state_q == LOCKED);
            case (state_q)
                SEARCH: if (any_hit) begin
                    offset_d = kmin;
                    if (LOCK_COUNT == 1) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else begin
                        state_d = VERIFY;
                        cnt_d   = CW'(1);
                    end
                end
                VERIFY: if (hit_same) begin
                    if (cnt_inc == LOCK_C) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (hit_other) begin
                    offset_d = kmin;
                    cnt_d    = CW'(1);
                end
                LOCKED: if (hit_same) begin
                    cnt_d = '0;
                end else if (hit_other) begin
                    // Offset is kept; the next SEARCH hit replaces it.
                    if (cnt_inc == UNLOCK_C) begin
                        state_d  = SEARCH;
                        cnt_d    = '0;
                        relock_d = (relock_q == '1) ? relock_q : relock_q + 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
        if (io_realign) begin
            state_d = SEARCH;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= SEARCH;
            prev_q         <= '0;
            offset_q       <= '0;
            cnt_q          <= '0;
            relock_q       <= '0;
            rx_out_q       <= '0;
            rx_out_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            offset_q       <= offset_d;
            cnt_q          <= cnt_d;
            relock_q       <= relock_d;
            rx_out_q       <= rx_out_d;
            rx_out_valid_q <= rx_out_valid_d;
        end
    end

    assign io_rx_out       = rx_out_q;
    assign io_rx_out_valid = rx_out_valid_q;
    assign io_locked       = (state_q == LOCKED);
    assign io_offset       = offset_q;
    assign io_relock_count = relock_q;

endmodule

// File: tb/tb_hbwif_word_aligner.sv
// Self-checking bench for hbwif_word_aligner: bit-stream scenarios with random data and gaps,
// compared against a queue-based reference model.
module tb_hbwif_word_aligner;
    localparam int W  = 10;
    localparam int OW = $clog2(W);
    localparam logic [W-1:0] PAT  = 10'b0101111100;
    // Data bits never form a run of five ones, so only real commas can match.
    localparam logic [W-1:0] MASK = 10'b1011011011;
    localparam int LC = 4;
    localparam int UC = 2;

    logic          clock, reset;
    logic [W-1:0]  io_rx_in;
    logic          io_rx_in_valid, io_bit_reverse, io_realign;
    logic [W-1:0]  io_rx_out;
    logic          io_rx_out_valid, io_locked;
    logic [OW-1:0] io_offset;
    logic [7:0]    io_relock_count;

    hbwif_word_aligner #(.WIDTH(W), .PATTERN(PAT), .LOCK_COUNT(LC), .UNLOCK_COUNT(UC)) dut (
        .clock           (clock),
        .reset           (reset),
        .io_rx_in        (io_rx_in),
        .io_rx_in_valid  (io_rx_in_valid),
        .io_bit_reverse  (io_bit_reverse),
        .io_realign      (io_realign),
        .io_rx_out       (io_rx_out),
        .io_rx_out_valid (io_rx_out_valid),
        .io_locked       (io_locked),
        .io_offset       (io_offset),
        .io_relock_count (io_relock_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    bit           stream[$];
    int           cstart[$];
    logic [W-1:0] raw[$];

    // Reference model state: 0 = searching, 1 = verifying, 2 = locked.
    int           m_state, m_off, m_cnt, m_relock;
    logic [W-1:0] m_out;
    bit           m_vld, m_dc;
    bit           hist[$];

    function automatic logic [W-1:0] rev(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[W-1-i];
        return r;
    endfunction

    function automatic logic [W-1:0] src_at(input int p);
        logic [W-1:0] r;
        for (int j = 0; j < W; j++) r[j] = stream[p+j];
        return r;
    endfunction

    function automatic int det(input int c);
        return cstart[c] / W + 1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_off = 0; m_cnt = 0; m_relock = 0;
        m_out = '0; m_vld = 0; m_dc = 0;
        hist = {};
        repeat (W) hist.push_back(1'b0);
    endtask

    task automatic model_step(input bit v, input logic [W-1:0] din, input bit rl, input bit rv);
        logic [W-1:0] dd, win;
        int kmin;
        bit same;
        m_dc = 0;
        if (v) begin
            dd = rv ? rev(din) : din;
            for (int i = 0; i < W; i++) hist.push_back(dd[i]);
            kmin = -1; same = 0;
            for (int k = W - 1; k >= 0; k--) begin
                for (int j = 0; j < W; j++) win[j] = hist[k+j];
                if (win == PAT) begin
                    kmin = k;
                    if (k == m_off) same = 1;
                end
            end
            for (int j = 0; j < W; j++) m_out[j] = hist[m_off+j];
            m_vld = (m_state == 2);
            m_dc  = rl;
            if (!rl && kmin >= 0) begin
                if (m_state == 0) begin
                    m_off = kmin;
                    if (LC == 1) begin m_state = 2; m_cnt = 0; end
                    else begin m_state = 1; m_cnt = 1; end
                end else if (m_state == 1) begin
                    if (same) begin
                        m_cnt++;
                        if (m_cnt == LC) begin m_state = 2; m_cnt = 0; end
                    end else begin
                        m_off = kmin; m_cnt = 1;
                    end
                end else begin
                    if (same) m_cnt = 0;
                    else begin
                        m_cnt++;
                        if (m_cnt == UC) begin
                            m_state = 0; m_cnt = 0;
                            if (m_relock < 255) m_relock++;
                        end
                    end
                end
            end
            repeat (W) void'(hist.pop_front());
        end else begin
            m_vld = 0;
        end
        if (rl) begin m_state = 0; m_cnt = 0; end
    endtask

    task automatic s_clear();
        stream = {}; cstart = {}; raw = {};
    endtask
    task automatic s_junk(input int n);
        repeat (n) stream.push_back(1'b0);
    endtask
    task automatic s_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) stream.push_back(w[i]);
    endtask
    task automatic s_comma();
        cstart.push_back(stream.size());
        s_word(PAT);
    endtask
    task automatic s_data(input int n);
        repeat (n) s_word(W'($urandom) & MASK);
    endtask
    task automatic s_cut();
        s_junk(W);
        for (int n = 0; (n + 1) * W <= stream.size(); n++) raw.push_back(src_at(n * W));
    endtask

    task automatic do_reset(input bit rv);
        reset = 1'b1; io_rx_in = '0; io_rx_in_valid = 1'b0; io_realign = 1'b0;
        io_bit_reverse = rv;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // Random idle gap, then one valid word; updates the model after each edge.
    task automatic feed(input int n, input bit rv, input bit rl);
        repeat ($urandom_range(0, 2)) begin
            io_rx_in_valid = 1'b0; io_rx_in = W'($urandom); io_realign = 1'b0;
            @(posedge clock); #1;
            model_step(1'b0, io_rx_in, 1'b0, rv);
        end
        io_rx_in_valid = 1'b1; io_realign = rl;
        io_rx_in = rv ? rev(raw[n]) : raw[n];
        @(posedge clock); #1;
        model_step(1'b1, io_rx_in, rl, rv);
        io_rx_in_valid = 1'b0; io_realign = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        checks++;
        if ({io_rx_out, io_rx_out_valid, io_locked, io_offset, io_relock_count} !== '0) begin
            errors++;
            $display("FAIL reset: out=%h v=%b lk=%b off=%0d rc=%0d, want all zero",
                     io_rx_out, io_rx_out_valid, io_locked, io_offset, io_relock_count);
        end
    endtask

    task automatic test_lock(input bit rv, input string nm);
        s_clear(); s_junk(3);
        repeat (4) begin s_comma(); s_data(1); end
        s_data(4); s_cut();
        do_reset(rv);
        for (int n = 0; n < raw.size(); n++) begin
            feed(n, rv, 1'b0);
            checks++;
            if ({io_rx_out, io_locked, io_offset, io_relock_count} !==
                {m_out, (m_state == 2), OW'(m_off), 8'(m_relock)} || io_rx_out_valid !== m_vld) begin
                errors++;
                $display("FAIL %s model n=%0d: out=%h v=%b lk=%b off=%0d rc=%0d, want %h %b %b %0d %0d",
                         nm, n, io_rx_out, io_rx_out_valid, io_locked, io_offset, io_relock_count,
                         m_out, m_vld, m_state == 2, m_off, m_relock);
            end
            checks++;
            if (io_locked !== (n >= det(3)) || (n == det(3) && io_offset !== OW'(3))) begin
                errors++;
                $display("FAIL %s lock n=%0d: lk=%b off=%0d, want lk=%b off=3",
                         nm, n, io_locked, io_offset, n >= det(3));
            end
            if (n > det(3)) begin
                checks++;
                if (io_rx_out_valid !== 1'b1 || io_rx_out !== src_at((n - 1) * W + 3)) begin
                    errors++;
                    $display("FAIL %s data n=%0d: out=%h v=%b, want %h v=1",
                             nm, n, io_rx_out, io_rx_out_valid, src_at((n - 1) * W + 3));
                end
            end
        end
    endtask

    task automatic test_verify_reoffset();
        s_clear(); s_junk(3);
        repeat (2) begin s_comma(); s_data(1); end
        s_junk(4);
        repeat (4) begin s_comma(); s_data(1); end
        s_data(3); s_cut();
        do_reset(1'b0);
        for (int n = 0; n < raw.size(); n++) begin
            feed(n, 1'b0, 1'b0);
            checks++;
            if ({io_rx_out, io_locked, io_offset, io_relock_count} !==
                {m_out, (m_state == 2), OW'(m_off), 8'(m_relock)} || io_rx_out_valid !== m_vld) begin
                errors++;
                $display("FAIL reoffset model n=%0d: out=%h v=%b lk=%b off=%0d rc=%0d, want %h %b %b %0d %0d",
                         n, io_rx_out, io_rx_out_valid, io_locked, io_offset, io_relock_count,
                         m_out, m_vld, m_state == 2, m_off, m_relock);
            end
            checks++;
            if (io_locked !== (n >= det(5)) || (n >= det(2) && io_offset !== OW'(7))) begin
                errors++;
                $display("FAIL reoffset n=%0d: lk=%b off=%0d, want lk=%b off=7",
                         n, io_locked, io_offset, n >= det(5));
            end
        end
    endtask

    task automatic test_unlock();
        s_clear(); s_junk(3);
        repeat (4) begin s_comma(); s_data(1); end
        s_junk(2);
        repeat (3) begin s_comma(); s_data(1); end
        s_data(2); s_cut();
        do_reset(1'b0);
        for (int n = 0; n < raw.size(); n++) begin
            feed(n, 1'b0, 1'b0);
            checks++;
            if ({io_rx_out, io_locked, io_offset, io_relock_count} !==
                {m_out, (m_state == 2), OW'(m_off), 8'(m_relock)} || io_rx_out_valid !== m_vld) begin
                errors++;
                $display("FAIL unlock model n=%0d: out=%h v=%b lk=%b off=%0d rc=%0d, want %h %b %b %0d %0d",
                         n, io_rx_out, io_rx_out_valid, io_locked, io_offset, io_relock_count,
                         m_out, m_vld, m_state == 2, m_off, m_relock);
            end
            if (n == det(5)) begin
                checks++;
                if (io_locked !== 1'b0 || io_relock_count !== 8'd1 || io_offset !== OW'(3)) begin
                    errors++;
                    $display("FAIL unlock exit: lk=%b rc=%0d off=%0d, want lk=0 rc=1 off=3",
                             io_locked, io_relock_count, io_offset);
                end
            end
            if (n == det(6)) begin
                checks++;
                if (io_locked !== 1'b0 || io_offset !== OW'(5)) begin
                    errors++;
                    $display("FAIL unlock research: lk=%b off=%0d, want lk=0 off=5", io_locked, io_offset);
                end
            end
        end
    endtask

    task automatic test_realign();
        s_clear(); s_junk(3);
        repeat (6) begin s_comma(); s_data(1); end
        s_data(2); s_cut();
        do_reset(1'b0);
        for (int n = 0; n < raw.size(); n++) begin
            feed(n, 1'b0, n == det(4));
            checks++;
            if ({io_rx_out, io_locked, io_offset, io_relock_count} !==
                {m_out, (m_state == 2), OW'(m_off), 8'(m_relock)} ||
                (!m_dc && io_rx_out_valid !== m_vld)) begin
                errors++;
                $display("FAIL realign model n=%0d: out=%h v=%b lk=%b off=%0d rc=%0d, want %h %b %b %0d %0d",
                         n, io_rx_out, io_rx_out_valid, io_locked, io_offset, io_relock_count,
                         m_out, m_vld, m_state == 2, m_off, m_relock);
            end
            if (n >= det(4)) begin
                checks++;
                if (io_locked !== 1'b0 || io_relock_count !== 8'd0 ||
                    (n > det(4) && io_rx_out_valid !== 1'b0)) begin
                    errors++;
                    $display("FAIL realign n=%0d: lk=%b rc=%0d v=%b, want lk=0 rc=0 v=0",
                             n, io_locked, io_relock_count, io_rx_out_valid);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        s_clear(); s_junk(3);
        repeat (4) begin s_comma(); s_data(1); end
        s_data(4); s_cut();
        do_reset(1'b0);
        for (int n = 0; n <= det(1); n++) feed(n, 1'b0, 1'b0);
        checks++;
        if (io_locked !== 1'b0 || io_offset !== OW'(3)) begin
            errors++;
            $display("FAIL midreset pre: lk=%b off=%0d, want lk=0 off=3", io_locked, io_offset);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({io_rx_out, io_rx_out_valid, io_locked, io_offset, io_relock_count} !== '0) begin
            errors++;
            $display("FAIL midreset async: out=%h v=%b lk=%b off=%0d rc=%0d, want all zero",
                     io_rx_out, io_rx_out_valid, io_locked, io_offset, io_relock_count);
        end
        @(posedge clock); #1 reset = 1'b0;
        model_reset();
        for (int n = 0; n < raw.size(); n++) begin
            feed(n, 1'b0, 1'b0);
            checks++;
            if ({io_rx_out, io_locked, io_offset, io_relock_count} !==
                {m_out, (m_state == 2), OW'(m_off), 8'(m_relock)} || io_rx_out_valid !== m_vld ||
                io_locked !== (n >= det(3))) begin
                errors++;
                $display("FAIL midreset relock n=%0d: out=%h v=%b lk=%b off=%0d rc=%0d, want %h %b %b %0d %0d",
                         n, io_rx_out, io_rx_out_valid, io_locked, io_offset, io_relock_count,
                         m_out, m_vld, n >= det(3), m_off, m_relock);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock(1'b0, "lock");
        test_verify_reoffset();
        test_unlock();
        test_lock(1'b1, "bitrev");
        test_realign();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
